// File: rtl/icb_add_pkg.sv
// Shared encodings and default register map for the ICB adder-slave master.
package icb_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        STEP_AUG = 2'd0,
        STEP_ADD = 2'd1,
        STEP_CTL = 2'd2,
        STEP_SUM = 2'd3
    } step_t;

    localparam logic [31:0] DEF_AUG_OFS = 32'h0000_0000;
    localparam logic [31:0] DEF_ADD_OFS = 32'h0000_0004;
    localparam logic [31:0] DEF_CTL_OFS = 32'h0000_0008;
    localparam logic [31:0] DEF_SUM_OFS = 32'h0000_000C;
    localparam logic [31:0] CTL_GO      = 32'h0000_0001;

endpackage

// File: rtl/icb_add_master.sv
// ICB initiator that loads two operands into an adder slave, kicks it, and reads back the sum.
// One transaction is outstanding at a time; a response error aborts the remaining steps.
module icb_add_master
    import icb_add_pkg::*;
#(
    parameter logic [31:0] AUG_OFS = DEF_AUG_OFS,
    parameter logic [31:0] ADD_OFS = DEF_ADD_OFS,
    parameter logic [31:0] CTL_OFS = DEF_CTL_OFS,
    parameter logic [31:0] SUM_OFS = DEF_SUM_OFS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [31:0] augend,
    input  logic [31:0] addend,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] sum,
    output logic        icb_cmd_valid,
    output logic        icb_cmd_read,
    output logic [31:0] icb_cmd_addr,
    output logic [31:0] icb_cmd_wdata,
    output logic [3:0]  icb_cmd_wmask,
    output logic        icb_rsp_ready,
    input  logic        icb_cmd_ready,
    input  logic        icb_rsp_valid,
    input  logic [31:0] icb_rsp_rdata,
    input  logic        icb_rsp_err
);

    state_t      state_r;
    state_t      state_nxt_s;
    step_t       step_r;
    step_t       step_nxt_s;
    logic [31:0] base_r;
    logic [31:0] aug_r;
    logic [31:0] add_r;
    logic [31:0] sum_r;
    logic        err_r;
    logic        start_acc_s;
    logic        rsp_hs_s;

    assign start_acc_s = (state_r == ST_IDLE) && start;
    assign rsp_hs_s    = (state_r == ST_RSP) && icb_rsp_valid;

    // State and step registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            step_r  <= STEP_AUG;
        end else begin
            state_r <= state_nxt_s;
            step_r  <= step_nxt_s;
        end
    end

    // Next-state and step sequencing
    always_comb begin
        state_nxt_s = state_r;
        step_nxt_s  = step_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_CMD;
                    step_nxt_s  = STEP_AUG;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (icb_cmd_ready) begin
                    state_nxt_s = ST_RSP;
                end else begin
                    state_nxt_s = ST_CMD;
                end
            end
            ST_RSP: begin
                if (!icb_rsp_valid) begin
                    state_nxt_s = ST_RSP;
                end else if (icb_rsp_err || (step_r == STEP_SUM)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CMD;
                    step_nxt_s  = step_t'(step_r + 2'd1);
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                step_nxt_s  = STEP_AUG;
            end
        endcase
    end

    // Operand capture, sum load and error flag; results persist until the next accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r <= 32'h0000_0000;
            aug_r  <= 32'h0000_0000;
            add_r  <= 32'h0000_0000;
            sum_r  <= 32'h0000_0000;
            err_r  <= 1'b0;
        end else if (start_acc_s) begin
            base_r <= base_addr;
            aug_r  <= augend;
            add_r  <= addend;
            err_r  <= 1'b0;
        end else if (rsp_hs_s) begin
            if (icb_rsp_err) begin
                err_r <= 1'b1;
            end else if (step_r == STEP_SUM) begin
                sum_r <= icb_rsp_rdata;
            end
        end
    end

    // Command field mux; fields depend only on registers so they hold steady while stalled
    always_comb begin
        icb_cmd_read  = 1'b0;
        icb_cmd_addr  = base_r + AUG_OFS;
        icb_cmd_wdata = aug_r;
        icb_cmd_wmask = 4'hF;
        case (step_r)
            STEP_AUG: begin
                icb_cmd_addr  = base_r + AUG_OFS;
                icb_cmd_wdata = aug_r;
            end
            STEP_ADD: begin
                icb_cmd_addr  = base_r + ADD_OFS;
                icb_cmd_wdata = add_r;
            end
            STEP_CTL: begin
                icb_cmd_addr  = base_r + CTL_OFS;
                icb_cmd_wdata = CTL_GO;
            end
            STEP_SUM: begin
                icb_cmd_read  = 1'b1;
                icb_cmd_addr  = base_r + SUM_OFS;
                icb_cmd_wdata = 32'h0000_0000;
                icb_cmd_wmask = 4'h0;
            end
            default: begin
                icb_cmd_read  = 1'b0;
                icb_cmd_addr  = base_r + AUG_OFS;
                icb_cmd_wdata = aug_r;
                icb_cmd_wmask = 4'hF;
            end
        endcase
    end

    assign icb_cmd_valid = (state_r == ST_CMD);
    assign icb_rsp_ready = (state_r == ST_RSP);
    assign busy          = (state_r != ST_IDLE);
    assign done          = (state_r == ST_DONE);
    assign err           = err_r;
    assign sum           = sum_r;

endmodule

// File: tb/tb_icb_add_master.sv
// Directed bench for icb_add_master: an in-line ICB slave with scripted stalls and a
// scoreboard queue of the command beats each sequence is expected to issue.
module tb_icb_add_master;

    typedef struct packed {
        logic        read;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } txn_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] augend;
    logic [31:0] addend;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] sum;
    logic        icb_cmd_valid;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_addr;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_ready;
    logic        icb_cmd_ready;
    logic        icb_rsp_valid;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;

    txn_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   dc;

    icb_add_master dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .augend        (augend),
        .addend        (addend),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .sum           (sum),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_rdata (icb_rsp_rdata),
        .icb_rsp_err   (icb_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [31:0] b, input logic [31:0] a, input logic [31:0] d,
                            input int n);
        txn_t t;
        for (int i = 0; i < n; i++) begin
            case (i)
                0:       t = '{1'b0, b + 32'h0, a, 4'hF};
                1:       t = '{1'b0, b + 32'h4, d, 4'hF};
                2:       t = '{1'b0, b + 32'h8, 32'h1, 4'hF};
                default: t = '{1'b1, b + 32'hC, 32'h0, 4'h0};
            endcase
            exp_q.push_back(t);
        end
    endtask

    // One add sequence with the bench acting as slave; stalls, error and disturbances scripted.
    task automatic run_seq(input logic [31:0] b, input logic [31:0] a, input logic [31:0] d,
                           input int err_step, input int cw_step, input int cw_n,
                           input int rw_step, input int rw_n,
                           input bit start_in_rsp2, input bit rst_in_cmd2,
                           output int done_cyc);
        int   n_cmd = 0;
        int   n_rsp = 0;
        int   cw = 0;
        int   rw = 0;
        int   cyc;
        bit   stop = 1'b0;
        txn_t e;
        push_exp(b, a, d, (err_step >= 0) ? err_step + 1 : 4);
        base_addr = b;
        augend    = a;
        addend    = d;
        start     = 1'b1;
        @(negedge clk);
        cyc      = 1;
        done_cyc = 0;
        while (!stop && cyc < 200) begin
            start         = 1'b0;
            icb_cmd_ready = 1'b0;
            icb_rsp_valid = 1'b0;
            icb_rsp_err   = 1'b0;
            icb_rsp_rdata = 32'h0;
            if (done) begin
                done_cyc = cyc;
                stop     = 1'b1;
            end else begin
                if (icb_cmd_valid) begin
                    if (rst_in_cmd2 && n_cmd == 2) begin
                        rst_n = 1'b0;
                        #1;
                        chk("rst_cmd_valid", {31'b0, icb_cmd_valid}, 32'h0);
                        chk("rst_rsp_ready", {31'b0, icb_rsp_ready}, 32'h0);
                        chk("rst_busy",      {31'b0, busy}, 32'h0);
                        chk("rst_done",      {31'b0, done}, 32'h0);
                        chk("rst_sum",       sum, 32'h0);
                        stop = 1'b1;
                    end else if (exp_q.size() == 0) begin
                        chk("extra_cmd", 32'h1, 32'h0);
                    end else begin
                        e = exp_q[0];
                        chk("cmd_read",  {31'b0, icb_cmd_read}, {31'b0, e.read});
                        chk("cmd_addr",  icb_cmd_addr, e.addr);
                        chk("cmd_wdata", icb_cmd_wdata, e.wdata);
                        chk("cmd_wmask", {28'b0, icb_cmd_wmask}, {28'b0, e.wmask});
                        if (n_cmd == cw_step && cw < cw_n) begin
                            cw++;
                        end else begin
                            icb_cmd_ready = 1'b1;
                            void'(exp_q.pop_front());
                            n_cmd++;
                        end
                    end
                end
                if (!stop && icb_rsp_ready) begin
                    if (start_in_rsp2 && n_rsp == 2) begin
                        start     = 1'b1;
                        base_addr = 32'hDEAD_0000;
                    end
                    if (n_rsp == rw_step && rw < rw_n) begin
                        rw++;
                    end else begin
                        icb_rsp_valid = 1'b1;
                        icb_rsp_err   = (n_rsp == err_step);
                        icb_rsp_rdata = a + d;
                        n_rsp++;
                    end
                end
            end
            if (!stop) begin
                @(negedge clk);
                cyc++;
            end
        end
        start         = 1'b0;
        icb_cmd_ready = 1'b0;
        icb_rsp_valid = 1'b0;
        icb_rsp_err   = 1'b0;
    endtask

    task automatic post_done(input string tag);
        chk({tag, "_queue_empty"}, exp_q.size(), 32'h0);
        @(negedge clk);
        chk({tag, "_done_once"}, {31'b0, done}, 32'h0);
        chk({tag, "_idle"},      {31'b0, busy}, 32'h0);
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        base_addr     = 32'h0;
        augend        = 32'h0;
        addend        = 32'h0;
        icb_cmd_ready = 1'b0;
        icb_rsp_valid = 1'b0;
        icb_rsp_rdata = 32'h0;
        icb_rsp_err   = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_cmd_valid", {31'b0, icb_cmd_valid}, 32'h0);
        chk("reset_rsp_ready", {31'b0, icb_rsp_ready}, 32'h0);
        chk("reset_busy",      {31'b0, busy}, 32'h0);
        chk("reset_done",      {31'b0, done}, 32'h0);
        chk("reset_err",       {31'b0, err}, 32'h0);
        chk("reset_sum",       sum, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait basic add
        run_seq(32'h1004_2000, 32'd5, 32'd7, -1, -1, 0, -1, 0, 1'b0, 1'b0, dc);
        chk("basic_done_cycle", dc, 32'd9);
        chk("basic_sum", sum, 32'd12);
        chk("basic_err", {31'b0, err}, 32'h0);
        post_done("basic");

        // Back-pressure: cmd stalled 3 on step 1, rsp delayed 2 on step 3; sum wraps
        run_seq(32'h2000_0100, 32'hFFFF_FFFF, 32'h2, -1, 1, 3, 3, 2, 1'b0, 1'b0, dc);
        chk("stall_done_cycle", dc, 32'd14);
        chk("stall_sum", sum, 32'h1);
        chk("stall_err", {31'b0, err}, 32'h0);
        post_done("stall");

        // Error response on step 1 aborts the sequence
        run_seq(32'h3000_0000, 32'd9, 32'd10, 1, -1, 0, -1, 0, 1'b0, 1'b0, dc);
        chk("err_done_cycle", dc, 32'd5);
        chk("err_flag", {31'b0, err}, 32'h1);
        chk("err_sum_kept", sum, 32'h1);
        post_done("err");
        repeat (3) @(negedge clk);
        chk("err_hold", {31'b0, err}, 32'h1);
        chk("err_no_cmd", {31'b0, icb_cmd_valid}, 32'h0);

        // Address wrap-around
        run_seq(32'hFFFF_FFF8, 32'd100, 32'd23, -1, -1, 0, -1, 0, 1'b0, 1'b0, dc);
        chk("wrap_done_cycle", dc, 32'd9);
        chk("wrap_sum", sum, 32'd123);
        chk("wrap_err_cleared", {31'b0, err}, 32'h0);
        post_done("wrap");

        // start pulsed during step-2 response is ignored
        run_seq(32'h4000_0000, 32'd3, 32'd4, -1, -1, 0, 2, 1, 1'b1, 1'b0, dc);
        chk("ign_done_cycle", dc, 32'd10);
        chk("ign_sum", sum, 32'd7);
        post_done("ign");
        repeat (3) begin
            @(negedge clk);
            chk("ign_stays_idle", {31'b0, busy}, 32'h0);
        end

        // Asynchronous reset during step-2 command
        run_seq(32'h5000_0000, 32'd1, 32'd2, -1, -1, 0, -1, 0, 1'b0, 1'b1, dc);
        chk("rst_no_done", dc, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // First sequence after reset restarts at step 0
        run_seq(32'h6000_0000, 32'd20, 32'd22, -1, -1, 0, -1, 0, 1'b0, 1'b0, dc);
        chk("restart_done_cycle", dc, 32'd9);
        chk("restart_sum", sum, 32'd42);
        chk("restart_err", {31'b0, err}, 32'h0);
        post_done("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
